// File: rtl/kernel_pipe.sv
// rtl/kernel_pipe.sv - pipelined 3x3 image-kernel engine (box, sharpen, strong sharpen, identity)
module kernel_pipe #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*PIX_W-1:0]      win,
    input  logic [1:0]              ksel,
    input  logic                    sat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] kresult,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        sat_cnt
);

    localparam int IW = PIX_W + 5;
    localparam logic [1:0] K_BOX   = 2'b00;
    localparam logic [1:0] K_SHARP = 2'b01;
    localparam logic [1:0] K_STRONG = 2'b10;
    localparam logic signed [IW-1:0] PIX_MAX = {{5{1'b0}}, {PIX_W{1'b1}}};

    logic w_advance;

    logic                 r_s1_v;
    logic [9*PIX_W-1:0]   r_s1_win;
    logic [1:0]           r_s1_ksel;
    logic                 r_s1_sat;

    logic                 r_s2_v;
    logic signed [IW-1:0] r_s2_sum;
    logic                 r_s2_box;
    logic                 r_s2_sat;

    logic                 r_s3_v;
    logic signed [IW-1:0] r_s3_val;
    logic                 r_s3_sat;

    logic signed [IW-1:0] w_pix [9];
    logic signed [IW-1:0] w_a;
    logic signed [IW-1:0] w_r;
    logic signed [IW-1:0] w_sum;
    logic signed [IW-1:0] w_norm;
    logic signed [IW-1:0] w_clamp;
    logic                 w_clip;

    // One global stall: every stage, bubbles included, moves only on advance.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_a = '0;
        for (int i = 0; i < 9; i++) begin
            w_pix[i] = $signed({{5{1'b0}}, r_s1_win[i*PIX_W +: PIX_W]});
            w_a      = w_a + w_pix[i];
        end
        w_r = w_a - w_pix[4];
        case (r_s1_ksel)
            K_BOX:    w_sum = w_a;
            K_SHARP:  w_sum = (w_pix[4] <<< 2) + w_pix[4] - w_pix[1] - w_pix[7] - w_pix[3] - w_pix[5];
            K_STRONG: w_sum = (w_pix[4] <<< 3) + w_pix[4] - w_r;
            default:  w_sum = w_pix[4];
        endcase
    end

    // Box sums are never negative, so an unsigned constant divide is exact.
    always_comb begin
        w_norm = r_s2_sum;
        if (r_s2_box) begin
            w_norm = $signed($unsigned(r_s2_sum) / IW'(9));
        end
    end

    always_comb begin
        w_clamp = r_s3_val;
        w_clip  = 1'b0;
        if (r_s3_sat) begin
            if (r_s3_val[IW-1]) begin
                w_clamp = '0;
                w_clip  = 1'b1;
            end else if (r_s3_val > PIX_MAX) begin
                w_clamp = PIX_MAX;
                w_clip  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_win  <= '0;
            r_s1_ksel <= '0;
            r_s1_sat  <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_sum  <= '0;
            r_s2_box  <= 1'b0;
            r_s2_sat  <= 1'b0;
            r_s3_v    <= 1'b0;
            r_s3_val  <= '0;
            r_s3_sat  <= 1'b0;
            out_valid <= 1'b0;
            kresult   <= '0;
            out_sat   <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            if (w_advance) begin
                r_s1_v    <= in_valid;
                r_s1_win  <= win;
                r_s1_ksel <= ksel;
                r_s1_sat  <= sat_en;
                r_s2_v    <= r_s1_v;
                r_s2_sum  <= w_sum;
                r_s2_box  <= (r_s1_ksel == K_BOX);
                r_s2_sat  <= r_s1_sat;
                r_s3_v    <= r_s2_v;
                r_s3_val  <= w_norm;
                r_s3_sat  <= r_s2_sat;
                out_valid <= r_s3_v;
                kresult   <= OUT_W'(w_clamp);
                out_sat   <= w_clip & r_s3_v;
            end
            if (out_valid && out_ready && out_sat && !(&sat_cnt)) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/kernel_pipe.md
# kernel_pipe

Parametrised, pipelined 3x3 image-kernel engine for the EXE stage. It accepts one 3x3 pixel window per beat over a valid/ready handshake and applies one of four selectable kernels: box mean, sharpen, strong sharpen or identity. Results can optionally be clamped to the pixel range, and the block counts clamped results. It replaces the earlier combinational kernel unit, keeps the same kernel arithmetic, and adds pipelining, back-pressure, width parameters and saturation.

## Interface
Parameters:
- PIX_W, 8, unsigned pixel width.
- OUT_W, 16, signed result width; must be >= PIX_W+5.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  window and mode are valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- win  in  9*PIX_W  pixel (r,c) at win[(3*r+c)*PIX_W +: PIX_W]; r=0 is the top row, c=0 is the left column, index 4 is the centre.
- ksel  in  2  kernel select, sampled with win.
- sat_en  in  1  clamp enable, sampled with win.
- out_valid  out  1  kresult is valid.
- out_ready  in  1  consumer accepts kresult.
- kresult  out  OUT_W  signed result.
- out_sat  out  1  the result was clamped.
- sat_cnt  out  CNT_W  number of clamped results delivered.

## Operation
- Kernels. C = centre, N/S/E/W = the four orthogonal neighbours, A = sum of all 9 pixels, R = sum of the 8 non-centre pixels.
  - 00 box mean: floor(A/9). Must be exact for every A up to 9*(2^PIX_W-1). Any divider implementation is allowed if it is exact.
  - 01 sharpen: 5*C - N - S - E - W.
  - 10 strong sharpen: 9*C - R.
  - 11 identity: C.
- Intermediate arithmetic is signed with PIX_W+5 bits. It cannot overflow.
- Pipeline stages:
  - S1 registers win, ksel and sat_en.
  - S2 computes the weighted sum, or A for box mode.
  - S3 does the normalisation (/9 or pass-through) and the clamp, then registers kresult and out_sat.
- Clamp:
  - sat_en=1: values < 0 become 0; values > 2^PIX_W-1 become 2^PIX_W-1. out_sat=1 only when a value was actually changed.
  - sat_en=0: the result is sign-extended to OUT_W and out_sat=0.
- sat_cnt increments by 1 on each output handshake (out_valid && out_ready) with out_sat=1. It holds at all-ones and does not wrap.
- ksel and sat_en may change on every beat. Each beat uses the mode it was accepted with.

## Timing
- Stall control is global: advance = !out_valid || out_ready, and in_ready = advance. Every stage's valid bit and data move only when advance=1. This holds even when the pipeline contains bubbles; the stall behaviour does not compress them.
- A beat is accepted when in_valid && in_ready at edge N. With no stall, out_valid=1 after edge N+3, i.e. latency 3 cycles.
- Throughput is 1 beat/cycle while out_ready=1.
- While out_valid && !out_ready, kresult, out_sat and out_valid hold stable, and in_ready=0.
- A beat offered with in_valid=0 enters the pipe as a bubble. in_valid=0 when in_ready=1 produces no output.
- Reset (rst_n=0 at an edge):
  - All stage valid bits, out_valid, kresult, out_sat and sat_cnt become 0.
  - In-flight beats are discarded, even mid-stall.
  - in_ready=1 from the first cycle after reset.
- Handshake and reset on the same edge: reset wins. The beat is not accepted and sat_cnt is not incremented.
- Simultaneous output handshake and input acceptance is legal and is the normal streaming case.

## Test plan
- Box mean, all pixels 11, ksel=00, sat_en=0 → kresult=11 three cycles after acceptance. All pixels 255 → 255. Window 0..8 (sum 36) → 4.
- Sharpen: all 11 except C=15, ksel=01 → 31. Strong sharpen: all 11 except C=22, ksel=10 → 110. Identity with C=200, ksel=11 → 200.
- Clamp: all 255 except C=0, ksel=10, sat_en=1 → kresult=0, out_sat=1, sat_cnt 0→1. Same beat with sat_en=0 → kresult=-2040 (16'hF808), out_sat=0, sat_cnt unchanged.
- Back-pressure: stream 6 beats cycling ksel 00→11 with out_ready toggled pseudo-randomly → results arrive in order with per-beat modes honoured, are held stable while stalled, and in_ready=0 exactly while out_valid && !out_ready.
- Counter saturation: CNT_W=2, deliver 5 clamped results → sat_cnt sequence 1,2,3,3,3.
- Reset mid-stream: assert rst_n=0 for one cycle while 3 beats are in flight and out_ready=0 → the next cycle shows out_valid=0, sat_cnt=0, in_ready=1, and no stale result ever appears afterwards.
